// File: rtl/neopixel_frame_sequencer.sv
// rtl/neopixel_frame_sequencer.sv - frame buffer and load/send sequencer for a NeoPixel strand controller
// Optional periodic auto-refresh is enabled by defining NEOPIXEL_AUTO_REFRESH_EN.
module neopixel_frame_sequencer #(
    parameter int NUM_PIXELS     = 5,
    parameter int ACK_TIMEOUT    = 16,
    parameter int REFRESH_CYCLES = 2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_pixel,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_level,
    input  logic       start,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic [7:0] color_level,
    output logic [1:0] color_index,
    output logic [2:0] pixel_index,
    output logic       load_color,
    output logic       send_it,
    output logic       busy,
    output logic       frame_done,
    output logic       wr_err,
    output logic       ack_err
);
    typedef enum logic [2:0] {
        IDLE, LOAD_WAIT, LOAD, SEND_WAIT, SEND, ACK, DRAIN
    } state_t;

    localparam int               ACK_W      = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [3:0]       PIX_COUNT  = 4'(NUM_PIXELS);
    localparam logic [2:0]       LAST_PIXEL = 3'(NUM_PIXELS - 1);
    localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);

    state_t           state, next_state;
    logic [7:0]       live   [NUM_PIXELS][3];
    logic [7:0]       shadow [NUM_PIXELS][3];
    logic [2:0]       pix;
    logic [1:0]       col;
    logic [ACK_W-1:0] ack_cnt;
    logic             wr_legal, last_entry, frame_start, refresh_due;

    assign wr_legal    = wr_en && (wr_color != 2'b11) && ({1'b0, wr_pixel} < PIX_COUNT);
    assign last_entry  = (pix == LAST_PIXEL) && (col == 2'd2);
    assign frame_start = (state == IDLE) && (start || refresh_due);

`ifdef NEOPIXEL_AUTO_REFRESH_EN
    localparam int                   REFRESH_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

    logic [REFRESH_W-1:0] refresh_timer;

    // Holds at the terminal count while a frame is running so the refresh fires on return to IDLE.
    assign refresh_due = (refresh_timer == REFRESH_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_timer <= '0;
        end else if (frame_start) begin
            refresh_timer <= '0;
        end else if (!refresh_due) begin
            refresh_timer <= refresh_timer + 1'b1;
        end
    end
`else
    assign refresh_due = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (frame_start) next_state = LOAD_WAIT;
            LOAD_WAIT: if (ready_to_load) next_state = LOAD;
            LOAD:      next_state = last_entry ? SEND_WAIT : LOAD_WAIT;
            SEND_WAIT: if (ready_to_send) next_state = SEND;
            SEND:      next_state = ACK;
            ACK: begin
                if (!ready_to_send) begin
                    next_state = DRAIN;
                end else if (ack_cnt == ACK_LAST) begin
                    next_state = IDLE;
                end
            end
            DRAIN:     if (ready_to_send) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    live[p][c]   <= '0;
                    shadow[p][c] <= '0;
                end
            end
            pix     <= '0;
            col     <= '0;
            ack_cnt <= '0;
        end else begin
            if (wr_legal) begin
                live[wr_pixel][wr_color] <= wr_level;
            end
            // Nonblocking copy takes the pre-write value when a write lands on the start edge.
            if (frame_start) begin
                shadow <= live;
                pix    <= '0;
                col    <= '0;
            end else if (state == LOAD) begin
                if (col == 2'd2) begin
                    col <= '0;
                    pix <= pix + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            ack_cnt <= (state == ACK) ? ack_cnt + 1'b1 : '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_level <= '0;
            color_index <= '0;
            pixel_index <= '0;
            load_color  <= 1'b0;
            send_it     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            wr_err      <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            load_color <= (next_state == LOAD);
            send_it    <= (next_state == SEND);
            busy       <= (next_state != IDLE);
            frame_done <= (state == DRAIN) && ready_to_send;
            ack_err    <= (state == ACK) && ready_to_send && (ack_cnt == ACK_LAST);
            wr_err     <= wr_en && !wr_legal;
            if (next_state == LOAD) begin
                color_level <= shadow[pix][col];
                color_index <= col;
                pixel_index <= pix;
            end else begin
                color_level <= '0;
                color_index <= '0;
                pixel_index <= '0;
            end
        end
    end
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// tb/tb_neopixel_frame_sequencer.sv - scoreboard bench for neopixel_frame_sequencer
module tb_neopixel_frame_sequencer;
    localparam int NP = 5;
    localparam int AT = 16;

    logic       clock = 1'b0;
    logic       reset, wr_en, start, ready_to_load, ready_to_send;
    logic [2:0] wr_pixel;
    logic [1:0] wr_color;
    logic [7:0] wr_level;
    logic [7:0] color_level;
    logic [1:0] color_index;
    logic [2:0] pixel_index;
    logic       load_color, send_it, busy, frame_done, wr_err, ack_err;

    neopixel_frame_sequencer #(
        .NUM_PIXELS(NP), .ACK_TIMEOUT(AT), .REFRESH_CYCLES(2_500_000)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel),
        .wr_color(wr_color), .wr_level(wr_level), .start(start),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .color_level(color_level), .color_index(color_index), .pixel_index(pixel_index),
        .load_color(load_color), .send_it(send_it), .busy(busy),
        .frame_done(frame_done), .wr_err(wr_err), .ack_err(ack_err)
    );

    always #10 clock = ~clock;

    int checks = 0, fails = 0;
    int n_send = 0, n_done = 0, n_ackerr = 0;
    int neg_cnt = 0, rise_at = 0, send_at = 0, frame_loads = 0;
    int s0 = 0, d0 = 0, a0 = 0;
    bit prev_busy = 1'b0, steady = 1'b1, stuck_ack = 1'b0;
    logic [12:0] exp_q[$];
    logic [7:0]  model [NP][3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected loads and checks strobe timing relative to the busy rise.
    always @(negedge clock) begin
        neg_cnt++;
        if (!reset) begin
            if (busy && !prev_busy) begin
                rise_at = neg_cnt;
                frame_loads = 0;
            end
            prev_busy = busy;
            if (load_color) begin
                if (exp_q.size() == 0) check("unexpected_load", 1, 0);
                else check("load_entry", {pixel_index, color_index, color_level}, exp_q.pop_front());
                if (steady) check("load_cycle", neg_cnt - rise_at, 1 + 2 * frame_loads);
                frame_loads++;
            end else begin
                check("entry_outputs_zero", {pixel_index, color_index, color_level}, 0);
            end
            if (send_it) begin
                n_send++;
                send_at = neg_cnt;
                if (steady) check("send_cycle", neg_cnt - rise_at, 6 * NP + 1);
            end
            if (frame_done) begin
                n_done++;
                check("busy_at_done", busy, 0);
            end
            if (ack_err) begin
                n_ackerr++;
                check("ack_err_cycle", neg_cnt - send_at, AT + 1);
                check("busy_at_ack_err", busy, 0);
            end
        end else begin
            prev_busy = 1'b0;
        end
    end

    // Strand controller model: ready_to_send drops for 2-4 cycles after each send_it.
    initial begin
        ready_to_load = 1'b0;
        ready_to_send = 1'b1;
        forever begin
            @(negedge clock);
            ready_to_load = steady ? 1'b1 : 1'($urandom_range(0, 1));
            if (send_it && !stuck_ack && !reset) begin
                ready_to_send = 1'b0;
                repeat ($urandom_range(2, 4)) @(negedge clock);
                ready_to_send = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic push_frame();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back({3'(p), 2'(c), model[p][c]});
    endtask

    task automatic host_write(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l,
                              input bit with_start);
        bit legal;
        legal = (c != 2'b11) && (int'(p) < NP);
        step();
        wr_en = 1'b1; wr_pixel = p; wr_color = c; wr_level = l;
        if (with_start) begin
            start = 1'b1;
            if (!busy) push_frame();
        end
        step();
        wr_en = 1'b0; start = 1'b0;
        check("wr_err", wr_err, legal ? 0 : 1);
        if (legal) model[p][c] = l;
    endtask

    task automatic start_frame();
        step();
        start = 1'b1;
        if (!busy) push_frame();
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        check("frame_finished", busy, 0);
        step();
    endtask

    task automatic frame_begin();
        s0 = n_send; d0 = n_done; a0 = n_ackerr;
    endtask

    task automatic frame_end(input int exp_done, input int exp_ack);
        check("send_count", n_send - s0, 1);
        check("done_count", n_done - d0, exp_done);
        check("ack_err_count", n_ackerr - a0, exp_ack);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {color_level, color_index, pixel_index, load_color, send_it,
                     busy, frame_done, wr_err, ack_err}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0;
        wr_pixel = '0; wr_color = '0; wr_level = '0;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) model[p][c] = '0;
        #25;
        check_outputs_zero("reset_outputs");
        step();
        reset = 1'b0;
        step();

        // Directed frame with two known entries and fixed strobe timing.
        host_write(3'd2, 2'd0, 8'hA5, 1'b0);
        host_write(3'd4, 2'd2, 8'h3C, 1'b0);
        frame_begin(); start_frame(); wait_idle(); frame_end(1, 0);

        // Illegal writes must leave the buffer untouched.
        host_write(3'd1, 2'd3, 8'hFF, 1'b0);
        host_write(3'd6, 2'd0, 8'hFF, 1'b0);
        host_write(3'd7, 2'd2, 8'h55, 1'b0);
        frame_begin(); start_frame(); wait_idle(); frame_end(1, 0);

        // Live write during a frame and an ignored start.
        host_write(3'd0, 2'd0, 8'h11, 1'b0);
        frame_begin();
        start_frame();
        n = 0;
        while (frame_loads < 2 && n < 200) begin step(); n++; end
        host_write(3'd0, 2'd0, 8'h22, 1'b0);
        start_frame();
        wait_idle(); frame_end(1, 0);
        frame_begin(); start_frame(); wait_idle(); frame_end(1, 0);

        // Controller never acknowledges the send.
        stuck_ack = 1'b1;
        frame_begin(); start_frame(); wait_idle(); frame_end(0, 1);
        stuck_ack = 1'b0;
        step();

        // Reset on the fifth load aborts the frame and clears the buffers.
        start_frame();
        n = 0;
        while (frame_loads < 5 && n < 200) begin step(); n++; end
        check("fifth_load_reached", frame_loads, 5);
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_frame_reset_outputs");
        exp_q.delete();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) model[p][c] = '0;
        step();
        reset = 1'b0;
        step();
        frame_begin(); start_frame(); wait_idle(); frame_end(1, 0);

        // Randomised writes, handshake stalls and same-cycle write+start.
        steady = 1'b0;
        repeat (8) begin
            frame_begin();
            repeat ($urandom_range(0, 4))
                host_write(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1)
                host_write(3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), 8'($urandom), 1'b1);
            else
                start_frame();
            repeat ($urandom_range(0, 3))
                host_write(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
            wait_idle();
            frame_end(1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
